action_pair_sched: RTL and testbench
====================================

Name: action_pair_sched

Overview:
- Sits between the parser/lookup stage and action_engine.
- PHVs reach this stage before their VLIW action words, because the action word comes from the lookup path, which has variable latency.
- The block buffers each stream in order and pairs the Nth PHV with the Nth action.
- It issues each pair to action_engine as one registered beat, with phv_valid and action_valid asserted together.

Parameters:
- PHV_LEN, 1124, PHV width in bits (48*8+32*8+16*8+5*20+256).
- ACT_LEN, 25, width of one ALU action slot.
- ACT_NUM, 25, number of action slots per VLIW word; action bus width = ACT_LEN*ACT_NUM (625).
- DEPTH, 4, entries per buffer (power of 2, minimum 2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- phv_in  in  PHV_LEN  PHV from parser/previous stage
- phv_valid_in  in  1  PHV beat valid
- phv_ready_out  out  1  PHV buffer can accept a beat
- action_in  in  ACT_LEN*ACT_NUM  VLIW action word from lookup
- action_valid_in  in  1  action beat valid
- action_ready_out  out  1  action buffer can accept a beat
- phv_out  out  PHV_LEN  PHV to action_engine
- phv_valid_out  out  1  PHV to action_engine valid
- action_out  out  ACT_LEN*ACT_NUM  action word to action_engine
- action_valid_out  out  1  action word valid; always equal to phv_valid_out
- pair_cnt  out  32  number of pairs issued since reset
- ovf_err  out  1  sticky flag: a beat arrived while its buffer was full
- outstanding  out  $clog2(DEPTH)+1  PHV buffer count minus action buffer count, saturating at 0

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - both buffers (count=0)
  - phv_out, action_out to 0
  - both valid outputs to 0
  - pair_cnt, ovf_err to 0
  - phv_ready_out and action_ready_out go to 1 once rst_n deasserts.
  - Reset mid-operation discards all buffered beats; there is no partial pair output.
- Buffers: two independent in-order FIFOs, P (PHV) and A (action), each DEPTH deep.
  - Write occurs when valid_in=1 and the buffer is not full.
  - ready_out = (count != DEPTH), combinational from registered count.
- Issue condition in cycle t: P non-empty and A non-empty.
  - Both FIFOs pop in cycle t.
  - The pair is registered and appears on the outputs in cycle t+1 with phv_valid_out=action_valid_out=1.
  - pair_cnt increments in t+1 and wraps at 2^32.
- When no issue occurs, valids go to 0 the next cycle and data outputs hold their last value.
- Latency:
  - Both beats arriving in the same cycle with both buffers empty: write in cycle t, issue decision in t+1, outputs valid in t+2. There is no combinational bypass.
  - A PHV waiting on its action leaves 2 cycles after the action arrives.
- Throughput: one pair per cycle sustained.
- Simultaneous push and pop on the same buffer while full: the push is refused (ready=0 is decided from the pre-pop count). The push is not lost silently; ovf_err is set.
- Push and pop on the same buffer while it holds 1..DEPTH-1 entries: count unchanged, data order preserved.
- Overflow: valid_in=1 while the buffer is full.
  - The beat is dropped.
  - ovf_err is set and stays set until reset.
  - No other state changes.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- outstanding = countP - countA when countP >= countA, otherwise 0.
- Sequencing FSM, states IDLE / WAIT_ACT / WAIT_PHV / ISSUE, registered:
  - Transitions are evaluated each cycle from post-update counts.
  - IDLE: both buffers empty.
  - WAIT_ACT: P non-empty, A empty.
  - WAIT_PHV: A non-empty, P empty.
  - ISSUE: both non-empty.
  - Pop is asserted only in ISSUE.
  - ISSUE→ISSUE while both buffers stay non-empty.

Decomposition:
- Shared package: PHV_LEN, ACT_LEN, ACT_NUM default constants and the FSM state encoding (2 bits).
- Sub-module: rmt_sync_fifo, a parameterised width/depth FIFO with full, empty, count, push, pop and asynchronous active-low reset. It is instantiated twice (P, A).
- The top level holds the FSM, the output registers and the counters.

Test Plan:
- Same-cycle pair: PHV {48'h111111111111,48'h222222222222,…} and action {4'b1010,5'd6,16'hffff,600'b0} both in cycle 5.
  - Required: phv_valid_out=action_valid_out=1 in cycle 7 only, with exact data; pair_cnt=1.
- Skewed arrival: 3 PHVs in cycles 5-7; actions with tags 1,2,3 in cycles 12-14.
  - Required: outstanding=3 at cycle 8.
  - Required: pairs out in cycles 14-16 in order (PHV1/act1 …); pair_cnt=3; outstanding returns to 0.
- Action-first: 2 actions, then PHVs 4 cycles later.
  - Required: state WAIT_PHV; pairs issue 2 cycles after each PHV; outstanding stays 0.
- Overflow: 5 PHVs back-to-back with no action (DEPTH=4).
  - Required: phv_ready_out=0 after 4th write; 5th dropped; ovf_err=1.
  - Then 4 actions: exactly 4 pairs out, the 5th PHV is never issued.
- Back-to-back streaming: 20 PHV and 20 action beats every cycle.
  - Required: 20 consecutive valid output cycles, ready never low, ovf_err=0.
- Reset mid-stream: assert rst_n=0 with 2 PHVs buffered.
  - Required: outputs 0 immediately.
  - After release: 1 action produces no output (WAIT_PHV); pair_cnt=0.

Source files
------------

// File: rtl/action_pair_sched_pkg.sv
// Shared constants and sequencing-state encoding for the PHV/action pairing stage.
package action_pair_sched_pkg;

    localparam int DEF_PHV_LEN = 1124;
    localparam int DEF_ACT_LEN = 25;
    localparam int DEF_ACT_NUM = 25;
    localparam int DEF_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACT = 2'd1,
        ST_WAIT_PHV = 2'd2,
        ST_ISSUE    = 2'd3
    } sched_state_t;

    function automatic sched_state_t state_from(input logic p_nonempty, input logic a_nonempty);
        case ({p_nonempty, a_nonempty})
            2'b11:   return ST_ISSUE;
            2'b10:   return ST_WAIT_ACT;
            2'b01:   return ST_WAIT_PHV;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rmt_sync_fifo.sv
// In-order synchronous FIFO; the head entry is presented combinationally on pop_data.
module rmt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // full is taken from the pre-pop count, so a push into a full FIFO is refused even if it pops.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/action_pair_sched.sv
// Buffers PHVs and VLIW action words separately and issues the Nth of each as one registered pair.
module action_pair_sched
    import action_pair_sched_pkg::*;
#(
    parameter int PHV_LEN = DEF_PHV_LEN,
    parameter int ACT_LEN = DEF_ACT_LEN,
    parameter int ACT_NUM = DEF_ACT_NUM,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PHV_LEN-1:0]           phv_in,
    input  logic                         phv_valid_in,
    output logic                         phv_ready_out,
    input  logic [ACT_LEN*ACT_NUM-1:0]   action_in,
    input  logic                         action_valid_in,
    output logic                         action_ready_out,
    output logic [PHV_LEN-1:0]           phv_out,
    output logic                         phv_valid_out,
    output logic [ACT_LEN*ACT_NUM-1:0]   action_out,
    output logic                         action_valid_out,
    output logic [31:0]                  pair_cnt,
    output logic                         ovf_err,
    output logic [$clog2(DEPTH):0]       outstanding,
    output sched_state_t                 dbg_state
);

    localparam int AW_BUS = ACT_LEN * ACT_NUM;
    localparam int CW     = $clog2(DEPTH) + 1;

    // Handshake: a beat transfers in a cycle where valid_in and ready_out are both 1;
    // ready_out depends only on registered counts, and valid_in may be held or dropped freely.
    logic                p_push, a_push, pop;
    logic                p_full, a_full, p_empty, a_empty;
    logic [PHV_LEN-1:0]  p_data;
    logic [AW_BUS-1:0]   a_data;
    logic [CW-1:0]       p_count, a_count;
    logic [CW-1:0]       p_cnt_nxt, a_cnt_nxt;
    sched_state_t        state;

    assign phv_ready_out    = !p_full;
    assign action_ready_out = !a_full;
    assign p_push           = phv_valid_in && !p_full;
    assign a_push           = action_valid_in && !a_full;
    assign pop              = (state == ST_ISSUE) && !p_empty && !a_empty;
    assign p_cnt_nxt        = p_count + CW'(p_push) - CW'(pop);
    assign a_cnt_nxt        = a_count + CW'(a_push) - CW'(pop);
    assign outstanding      = (p_count >= a_count) ? (p_count - a_count) : '0;
    assign dbg_state        = state;

    rmt_sync_fifo #(.WIDTH(PHV_LEN), .DEPTH(DEPTH)) u_phv_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (p_push),
        .push_data (phv_in),
        .pop       (pop),
        .pop_data  (p_data),
        .full      (p_full),
        .empty     (p_empty),
        .count     (p_count)
    );

    rmt_sync_fifo #(.WIDTH(AW_BUS), .DEPTH(DEPTH)) u_act_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (action_in),
        .pop       (pop),
        .pop_data  (a_data),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count)
    );

    // State tracks the post-update occupancy, so ISSUE in a cycle means both heads are present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            phv_out          <= '0;
            action_out       <= '0;
            phv_valid_out    <= 1'b0;
            action_valid_out <= 1'b0;
            pair_cnt         <= '0;
            ovf_err          <= 1'b0;
        end else begin
            state            <= state_from(p_cnt_nxt != '0, a_cnt_nxt != '0);
            phv_valid_out    <= pop;
            action_valid_out <= pop;
            if (pop) begin
                phv_out    <= p_data;
                action_out <= a_data;
                pair_cnt   <= pair_cnt + 32'd1;
            end
            if ((phv_valid_in && p_full) || (action_valid_in && a_full)) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_action_pair_sched.sv
// Directed bench for action_pair_sched: vector table plus hand-written multi-cycle sequences.
module tb_action_pair_sched;
  import action_pair_sched_pkg::*;

  localparam int PL = 1124;
  localparam int AL = 625;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PL-1:0]  phv_in = '0;
  logic           phv_valid_in = 1'b0;
  logic           phv_ready_out;
  logic [AL-1:0]  action_in = '0;
  logic           action_valid_in = 1'b0;
  logic           action_ready_out;
  logic [PL-1:0]  phv_out;
  logic           phv_valid_out;
  logic [AL-1:0]  action_out;
  logic           action_valid_out;
  logic [31:0]    pair_cnt;
  logic           ovf_err;
  logic [2:0]     outstanding;
  sched_state_t   dbg_state;

  always #5 clk = ~clk;

  action_pair_sched dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .phv_in           (phv_in),
    .phv_valid_in     (phv_valid_in),
    .phv_ready_out    (phv_ready_out),
    .action_in        (action_in),
    .action_valid_in  (action_valid_in),
    .action_ready_out (action_ready_out),
    .phv_out          (phv_out),
    .phv_valid_out    (phv_valid_out),
    .action_out       (action_out),
    .action_valid_out (action_valid_out),
    .pair_cnt         (pair_cnt),
    .ovf_err          (ovf_err),
    .outstanding      (outstanding),
    .dbg_state        (dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic         rst;
    logic         pv;
    logic [7:0]   pt;
    logic         av;
    logic [7:0]   at;
    logic         ev;
    logic [7:0]   et;
    logic [31:0]  cnt;
    logic [2:0]   outs;
    logic         pr;
    logic         ar;
    logic         ovf;
    sched_state_t st;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;

  logic [7:0] last_tag;
  logic       have_last;

  function automatic logic [PL-1:0] mk_phv(input logic [7:0] t);
    logic [PL-1:0] v;
    v = '0;
    v[7:0] = t;
    v[600 +: 8] = t ^ 8'h3c;
    v[PL-1 -: 8] = ~t;
    return v;
  endfunction

  function automatic logic [AL-1:0] mk_act(input logic [7:0] t);
    logic [AL-1:0] v;
    v = '0;
    v[7:0] = t ^ 8'h5a;
    v[300 +: 8] = t;
    v[AL-1 -: 8] = t + 8'h11;
    return v;
  endfunction

  task automatic chk_n(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  task automatic chk_w(input string nm, input logic [PL-1:0] a, input logic [PL-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (low 128 bits)", nm, a[127:0], e[127:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [7:0] pt, input logic av, input logic [7:0] at);
    phv_valid_in    = pv;
    phv_in          = pv ? mk_phv(pt) : '0;
    action_valid_in = av;
    action_in       = av ? mk_act(at) : '0;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    rst_n = 1'b0;
    have_last = 1'b0;
    last_tag = 8'd0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic add(input int r, input int pv, input int pt, input int av, input int at,
                     input int ev, input int et, input int c, input int o,
                     input int pr, input int ar, input int ovf, input sched_state_t st);
    tbl[n_vec].rst  = 1'(r);
    tbl[n_vec].pv   = 1'(pv);
    tbl[n_vec].pt   = 8'(pt);
    tbl[n_vec].av   = 1'(av);
    tbl[n_vec].at   = 8'(at);
    tbl[n_vec].ev   = 1'(ev);
    tbl[n_vec].et   = 8'(et);
    tbl[n_vec].cnt  = 32'(c);
    tbl[n_vec].outs = 3'(o);
    tbl[n_vec].pr   = 1'(pr);
    tbl[n_vec].ar   = 1'(ar);
    tbl[n_vec].ovf  = 1'(ovf);
    tbl[n_vec].st   = st;
    n_vec++;
  endtask

  task automatic run_table();
    vec_t v;
    logic [PL-1:0] ep;
    logic [AL-1:0] ea;
    for (int i = 0; i < n_vec; i++) begin
      v = tbl[i];
      if (v.rst) do_reset();
      drive(v.pv, v.pt, v.av, v.at);
      step();
      chk_n($sformatf("v%0d phv_valid", i), 32'(phv_valid_out), 32'(v.ev));
      chk_n($sformatf("v%0d act_valid", i), 32'(action_valid_out), 32'(v.ev));
      if (v.ev) begin
        have_last = 1'b1;
        last_tag = v.et;
      end
      ep = have_last ? mk_phv(last_tag) : '0;
      ea = have_last ? mk_act(last_tag) : '0;
      chk_w($sformatf("v%0d phv_out", i), phv_out, ep);
      chk_w($sformatf("v%0d act_out", i), PL'(action_out), PL'(ea));
      chk_n($sformatf("v%0d pair_cnt", i), pair_cnt, v.cnt);
      chk_n($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(v.outs));
      chk_n($sformatf("v%0d phv_ready", i), 32'(phv_ready_out), 32'(v.pr));
      chk_n($sformatf("v%0d act_ready", i), 32'(action_ready_out), 32'(v.ar));
      chk_n($sformatf("v%0d ovf_err", i), 32'(ovf_err), 32'(v.ovf));
      chk_n($sformatf("v%0d state", i), 32'(dbg_state), 32'(v.st));
    end
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PL-1:0] sp;
    logic [AL-1:0] sa;
    logic [7:0]    exp_q[$];
    logic [7:0]    tag;
    int            n_valid;
    int            run;
    int            max_run;

    // Reset state
    do_reset();
    chk_n("rst phv_valid", 32'(phv_valid_out), 32'd0);
    chk_n("rst act_valid", 32'(action_valid_out), 32'd0);
    chk_w("rst phv_out", phv_out, '0);
    chk_w("rst act_out", PL'(action_out), '0);
    chk_n("rst pair_cnt", pair_cnt, 32'd0);
    chk_n("rst ovf_err", 32'(ovf_err), 32'd0);
    chk_n("rst phv_ready", 32'(phv_ready_out), 32'd1);
    chk_n("rst act_ready", 32'(action_ready_out), 32'd1);
    chk_n("rst outstanding", 32'(outstanding), 32'd0);
    chk_n("rst state", 32'(dbg_state), 32'(ST_IDLE));

    // Same-cycle pair with literal data: valid exactly two cycles after the write cycle
    sp = '0;
    sp[PL-1 -: 48] = 48'h111111111111;
    sp[PL-49 -: 48] = 48'h222222222222;
    sp[15:0] = 16'hbeef;
    sa = {4'b1010, 5'd6, 16'hffff, 600'b0};
    phv_in = sp; phv_valid_in = 1'b1;
    action_in = sa; action_valid_in = 1'b1;
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    chk_n("pair t+1 valid", 32'(phv_valid_out), 32'd0);
    chk_n("pair t+1 state", 32'(dbg_state), 32'(ST_ISSUE));
    step();
    chk_n("pair t+2 phv_valid", 32'(phv_valid_out), 32'd1);
    chk_n("pair t+2 act_valid", 32'(action_valid_out), 32'd1);
    chk_w("pair t+2 phv_out", phv_out, sp);
    chk_w("pair t+2 act_out", PL'(action_out), PL'(sa));
    chk_n("pair t+2 pair_cnt", pair_cnt, 32'd1);
    step();
    chk_n("pair t+3 valid", 32'(phv_valid_out), 32'd0);
    chk_w("pair t+3 phv hold", phv_out, sp);
    chk_w("pair t+3 act hold", PL'(action_out), PL'(sa));
    chk_n("pair t+3 pair_cnt", pair_cnt, 32'd1);

    // Skewed arrival: three PHVs, then three actions five cycles later
    add(1, 1, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 2, 0, 0,  0, 0, 0, 2, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 3, 0, 0,  0, 0, 0, 3, 1, 1, 0, ST_WAIT_ACT);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0,  0, 0, 0, 3, 1, 1, 0, ST_WAIT_ACT);
    add(0, 0, 0, 1, 1,  0, 0, 0, 2, 1, 1, 0, ST_ISSUE);
    add(0, 0, 0, 1, 2,  1, 1, 1, 1, 1, 1, 0, ST_ISSUE);
    add(0, 0, 0, 1, 3,  1, 2, 2, 0, 1, 1, 0, ST_ISSUE);
    add(0, 0, 0, 0, 0,  1, 3, 3, 0, 1, 1, 0, ST_IDLE);
    add(0, 0, 0, 0, 0,  0, 0, 3, 0, 1, 1, 0, ST_IDLE);
    // Action first: outstanding saturates at 0 while actions lead
    add(1, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1, 0, ST_WAIT_PHV);
    add(0, 0, 0, 1, 2,  0, 0, 0, 0, 1, 1, 0, ST_WAIT_PHV);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, ST_WAIT_PHV);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, ST_WAIT_PHV);
    add(0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 1, 0, ST_ISSUE);
    add(0, 1, 2, 0, 0,  1, 1, 1, 0, 1, 1, 0, ST_ISSUE);
    add(0, 0, 0, 0, 0,  1, 2, 2, 0, 1, 1, 0, ST_IDLE);
    add(0, 0, 0, 0, 0,  0, 0, 2, 0, 1, 1, 0, ST_IDLE);
    // Overflow: fifth PHV dropped, four pairs only
    add(1, 1, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 2, 0, 0,  0, 0, 0, 2, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 3, 0, 0,  0, 0, 0, 3, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 4, 0, 0,  0, 0, 0, 4, 0, 1, 0, ST_WAIT_ACT);
    add(0, 1, 5, 0, 0,  0, 0, 0, 4, 0, 1, 1, ST_WAIT_ACT);
    add(0, 0, 0, 1, 1,  0, 0, 0, 3, 0, 1, 1, ST_ISSUE);
    add(0, 0, 0, 1, 2,  1, 1, 1, 2, 1, 1, 1, ST_ISSUE);
    add(0, 0, 0, 1, 3,  1, 2, 2, 1, 1, 1, 1, ST_ISSUE);
    add(0, 0, 0, 1, 4,  1, 3, 3, 0, 1, 1, 1, ST_ISSUE);
    add(0, 0, 0, 0, 0,  1, 4, 4, 0, 1, 1, 1, ST_IDLE);
    add(0, 0, 0, 0, 0,  0, 0, 4, 0, 1, 1, 1, ST_IDLE);
    // Push into a full PHV buffer in the same cycle it pops: refused, flagged, order kept
    add(1, 1, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 2, 0, 0,  0, 0, 0, 2, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 3, 0, 0,  0, 0, 0, 3, 1, 1, 0, ST_WAIT_ACT);
    add(0, 1, 4, 0, 0,  0, 0, 0, 4, 0, 1, 0, ST_WAIT_ACT);
    add(0, 0, 0, 1, 1,  0, 0, 0, 3, 0, 1, 0, ST_ISSUE);
    add(0, 1, 9, 1, 2,  1, 1, 1, 2, 1, 1, 1, ST_ISSUE);
    add(0, 0, 0, 0, 0,  1, 2, 2, 2, 1, 1, 1, ST_WAIT_ACT);
    add(0, 0, 0, 1, 3,  0, 0, 2, 1, 1, 1, 1, ST_ISSUE);
    add(0, 0, 0, 0, 0,  1, 3, 3, 1, 1, 1, 1, ST_WAIT_ACT);
    run_table();

    // Back-to-back streaming of 20 pairs
    do_reset();
    n_valid = 0;
    run = 0;
    max_run = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 20) begin
        drive(1'b1, 8'(k + 1), 1'b1, 8'(k + 1));
        exp_q.push_back(8'(k + 1));
      end else begin
        drive(1'b0, 8'd0, 1'b0, 8'd0);
      end
      if (k < 20) begin
        chk_n($sformatf("stream c%0d ready", k), 32'({phv_ready_out, action_ready_out}), 32'd3);
      end
      step();
      chk_n($sformatf("stream c%0d valid pair", k), 32'(action_valid_out), 32'(phv_valid_out));
      if (phv_valid_out) begin
        n_valid++;
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          chk_n("stream extra output", 32'd1, 32'd0);
        end else begin
          tag = exp_q.pop_front();
          chk_w($sformatf("stream phv %0d", tag), phv_out, mk_phv(tag));
          chk_w($sformatf("stream act %0d", tag), PL'(action_out), PL'(mk_act(tag)));
        end
      end else begin
        run = 0;
      end
    end
    chk_n("stream valid count", 32'(n_valid), 32'd20);
    chk_n("stream consecutive", 32'(max_run), 32'd20);
    chk_n("stream leftover", 32'(exp_q.size()), 32'd0);
    chk_n("stream pair_cnt", pair_cnt, 32'd20);
    chk_n("stream ovf_err", 32'(ovf_err), 32'd0);

    // Reset mid-stream with two PHVs buffered and nonzero held outputs
    do_reset();
    drive(1'b1, 8'd1, 1'b1, 8'd1);
    step();
    drive(1'b1, 8'd2, 1'b0, 8'd0);
    step();
    drive(1'b1, 8'd3, 1'b0, 8'd0);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    chk_n("mid pre outstanding", 32'(outstanding), 32'd2);
    chk_w("mid pre phv hold", phv_out, mk_phv(8'd1));
    #1;
    rst_n = 1'b0;
    #1;
    chk_w("mid rst phv_out", phv_out, '0);
    chk_w("mid rst act_out", PL'(action_out), '0);
    chk_n("mid rst valids", 32'({phv_valid_out, action_valid_out}), 32'd0);
    chk_n("mid rst pair_cnt", pair_cnt, 32'd0);
    chk_n("mid rst outstanding", 32'(outstanding), 32'd0);
    chk_n("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_n("mid rel ready", 32'({phv_ready_out, action_ready_out}), 32'd3);
    drive(1'b0, 8'd0, 1'b1, 8'd7);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    chk_n("mid act state", 32'(dbg_state), 32'(ST_WAIT_PHV));
    step();
    step();
    chk_n("mid act valid", 32'(phv_valid_out), 32'd0);
    chk_n("mid act pair_cnt", pair_cnt, 32'd0);
    chk_n("mid act outstanding", 32'(outstanding), 32'd0);
    chk_n("mid act state hold", 32'(dbg_state), 32'(ST_WAIT_PHV));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
